proc_control: RTL and testbench

Multicycle control unit for the 16-bit processor datapath. It sequences the eight-register file (R0–R6 general purpose, R7 program counter with increment/clear), the 10-bit instruction register, the A and G ALU registers and a synchronous memory port over the shared bus. It also runs the Run/Done handshake with the host. It is a pure sequencer: it holds no data, only state, and drives one-hot enables and bus selects.

---
 rtl/proc_control.sv | 190 +++++++++++++++++++
 tb/tb_proc_control.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/proc_control.sv
// Multicycle sequencer for the 16-bit processor datapath: fetch, execute and Run/Done handshake.
// Build option: define PROC_MVNZ_EN to enable conditional move (opcode 0110); otherwise it is a NOP.
module proc_control (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       Run,
   input  logic [9:0] IR,
   input  logic       Gnz,
   output logic       Done,
   output logic       IRin,
   output logic [7:0] Rin,
   output logic [7:0] Rout,
   output logic       PCinc,
   output logic       PCclr,
   output logic       Ain,
   output logic       Gin,
   output logic       Gout,
   output logic       DINout,
   output logic [1:0] ALUop,
   output logic       ADDRin,
   output logic       DOUTin,
   output logic       W
);

   // state  | meaning
   // RSTPC  | clear program counter after reset
   // IDLE   | wait for Run
   // F0     | PC onto bus, load memory address
   // F1     | memory latency, increment PC
   // F2     | load instruction register
   // E0..E2 | execute steps, opcode dependent; Done in the final one
   typedef enum logic [2:0] {
      S_RSTPC = 3'd0,
      S_IDLE  = 3'd1,
      S_F0    = 3'd2,
      S_F1    = 3'd3,
      S_F2    = 3'd4,
      S_E0    = 3'd5,
      S_E1    = 3'd6,
      S_E2    = 3'd7
   } state_t;

   localparam logic [3:0] OP_MV   = 4'b0000;
   localparam logic [3:0] OP_MVI  = 4'b0001;
   localparam logic [3:0] OP_ADD  = 4'b0010;
   localparam logic [3:0] OP_SUB  = 4'b0011;
   localparam logic [3:0] OP_LD   = 4'b0100;
   localparam logic [3:0] OP_ST   = 4'b0101;
   localparam logic [3:0] OP_MVNZ = 4'b0110;
   localparam logic [3:0] OP_AND  = 4'b0111;

   localparam logic [1:0] ALU_ADD = 2'b00;
   localparam logic [1:0] ALU_SUB = 2'b01;
   localparam logic [1:0] ALU_AND = 2'b10;

   state_t     state_q, state_d;
   logic [3:0] opcode;
   logic [7:0] x_sel, y_sel;
   logic       is_alu;
   logic       mvnz_move;
   logic [1:0] alu_sel;

   assign opcode = IR[9:6];
   assign x_sel  = 8'b0000_0001 << IR[5:3];
   assign y_sel  = 8'b0000_0001 << IR[2:0];
   assign is_alu = (opcode == OP_ADD) || (opcode == OP_SUB) || (opcode == OP_AND);

   always_comb begin
      alu_sel = ALU_ADD;
      if (opcode == OP_SUB) alu_sel = ALU_SUB;
      if (opcode == OP_AND) alu_sel = ALU_AND;
   end

`ifdef PROC_MVNZ_EN
   assign mvnz_move = (opcode == OP_MVNZ) && Gnz;
`else
   // Gnz has no consumer when conditional move is disabled.
   logic unused_gnz;
   assign unused_gnz = Gnz;
   assign mvnz_move  = 1'b0;
`endif

   always_comb begin
      state_d = state_q;
      Done    = 1'b0;
      IRin    = 1'b0;
      Rin     = 8'h00;
      Rout    = 8'h00;
      PCinc   = 1'b0;
      PCclr   = 1'b0;
      Ain     = 1'b0;
      Gin     = 1'b0;
      Gout    = 1'b0;
      DINout  = 1'b0;
      ALUop   = ALU_ADD;
      ADDRin  = 1'b0;
      DOUTin  = 1'b0;
      W       = 1'b0;

      case (state_q)
         S_RSTPC: begin
            PCclr   = 1'b1;
            state_d = S_IDLE;
         end
         S_IDLE: begin
            if (Run) state_d = S_F0;
         end
         S_F0: begin
            Rout    = 8'h80;
            ADDRin  = 1'b1;
            state_d = S_F1;
         end
         S_F1: begin
            PCinc   = 1'b1;
            state_d = S_F2;
         end
         S_F2: begin
            IRin    = 1'b1;
            state_d = S_E0;
         end
         S_E0: begin
            state_d = S_E1;
            case (opcode)
               OP_MV: begin
                  Rout = y_sel;
                  Rin  = x_sel;
                  Done = 1'b1;
               end
               OP_MVI: begin
                  Rout   = 8'h80;
                  ADDRin = 1'b1;
               end
               OP_ADD, OP_SUB, OP_AND: begin
                  Rout = x_sel;
                  Ain  = 1'b1;
               end
               OP_LD, OP_ST: begin
                  Rout   = y_sel;
                  ADDRin = 1'b1;
               end
               default: begin
                  // mvnz (when enabled) and every undefined opcode finish here
                  if (mvnz_move) begin
                     Rout = y_sel;
                     Rin  = x_sel;
                  end
                  Done = 1'b1;
               end
            endcase
         end
         S_E1: begin
            state_d = S_E2;
            if (opcode == OP_MVI) begin
               PCinc = 1'b1;
            end else if (is_alu) begin
               Rout  = y_sel;
               Gin   = 1'b1;
               ALUop = alu_sel;
            end else if (opcode == OP_ST) begin
               Rout   = x_sel;
               DOUTin = 1'b1;
               W      = 1'b1;
               Done   = 1'b1;
            end
         end
         S_E2: begin
            state_d = S_IDLE;
            if ((opcode == OP_MVI) || (opcode == OP_LD)) begin
               DINout = 1'b1;
               Rin    = x_sel;
               Done   = 1'b1;
            end else if (is_alu) begin
               Gout = 1'b1;
               Rin  = x_sel;
               Done = 1'b1;
            end
         end
         default: state_d = S_RSTPC;
      endcase

      // Run is only looked at here and in IDLE; back-to-back fetch skips IDLE.
      if (Done) state_d = Run ? S_F0 : S_IDLE;
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) state_q <= S_RSTPC;
      else       state_q <= state_d;
   end

endmodule

// File: tb/tb_proc_control.sv
// Bench for proc_control: directed scenarios plus a random instruction stream against a per-instruction step table.
module tb_proc_control;

   logic       Clock = 1'b0;
   logic       Reset = 1'b1;
   logic       Run   = 1'b0;
   logic [9:0] IR    = 10'd0;
   logic       Gnz   = 1'b0;
   logic       Done, IRin, PCinc, PCclr, Ain, Gin, Gout, DINout, ADDRin, DOUTin, W;
   logic [7:0] Rin, Rout;
   logic [1:0] ALUop;

   int checks   = 0;
   int failures = 0;
   bit next_f0  = 1'b0;

   proc_control dut (
      .Clock(Clock), .Reset(Reset), .Run(Run), .IR(IR), .Gnz(Gnz),
      .Done(Done), .IRin(IRin), .Rin(Rin), .Rout(Rout), .PCinc(PCinc), .PCclr(PCclr),
      .Ain(Ain), .Gin(Gin), .Gout(Gout), .DINout(DINout), .ALUop(ALUop),
      .ADDRin(ADDRin), .DOUTin(DOUTin), .W(W)
   );

   always #5 Clock = ~Clock;

   logic [28:0] obs;
   assign obs = {Done, IRin, Rin, Rout, PCinc, PCclr, Ain, Gin, Gout, DINout, ALUop, ADDRin, DOUTin, W};

   function automatic logic [28:0] pk(input logic done, input logic irin, input logic [7:0] rin,
                                      input logic [7:0] rout, input logic pcinc, input logic pcclr,
                                      input logic ain, input logic gin, input logic gout,
                                      input logic dinout, input logic [1:0] aluop,
                                      input logic addrin, input logic doutin, input logic w);
      return {done, irin, rin, rout, pcinc, pcclr, ain, gin, gout, dinout, aluop, addrin, doutin, w};
   endfunction

   function automatic int instr_len(input logic [3:0] op);
      case (op)
         4'd0:                       return 4;
         4'd1, 4'd2, 4'd3, 4'd4, 4'd7: return 6;
         4'd5:                       return 5;
         default:                    return 4;
      endcase
   endfunction

   // Expected outputs for cycle k (0 = F0) of an instruction.
   function automatic logic [28:0] exp_step(input logic [3:0] op, input logic [2:0] x,
                                            input logic [2:0] y, input logic g, input int k);
      logic [7:0] rx, ry;
      logic [1:0] aop;
      int e;
      rx  = 8'd1 << x;
      ry  = 8'd1 << y;
      aop = (op == 4'd2) ? 2'b00 : (op == 4'd3) ? 2'b01 : 2'b10;
      e   = k - 3;
      if (k == 0) return pk(0,0,0,8'h80,0,0,0,0,0,0,0,1,0,0);
      if (k == 1) return pk(0,0,0,0,1,0,0,0,0,0,0,0,0,0);
      if (k == 2) return pk(0,1,0,0,0,0,0,0,0,0,0,0,0,0);
      case (op)
         4'd0: return pk(1,0,rx,ry,0,0,0,0,0,0,0,0,0,0);
         4'd1: begin
            if (e == 0) return pk(0,0,0,8'h80,0,0,0,0,0,0,0,1,0,0);
            if (e == 1) return pk(0,0,0,0,1,0,0,0,0,0,0,0,0,0);
            return pk(1,0,rx,0,0,0,0,0,0,1,0,0,0,0);
         end
         4'd2, 4'd3, 4'd7: begin
            if (e == 0) return pk(0,0,0,rx,0,0,1,0,0,0,0,0,0,0);
            if (e == 1) return pk(0,0,0,ry,0,0,0,1,0,0,aop,0,0,0);
            return pk(1,0,rx,0,0,0,0,0,1,0,0,0,0,0);
         end
         4'd4: begin
            if (e == 0) return pk(0,0,0,ry,0,0,0,0,0,0,0,1,0,0);
            if (e == 1) return 29'd0;
            return pk(1,0,rx,0,0,0,0,0,0,1,0,0,0,0);
         end
         4'd5: begin
            if (e == 0) return pk(0,0,0,ry,0,0,0,0,0,0,0,1,0,0);
            return pk(1,0,0,rx,0,0,0,0,0,0,0,0,1,1);
         end
`ifdef PROC_MVNZ_EN
         4'd6: return g ? pk(1,0,rx,ry,0,0,0,0,0,0,0,0,0,0) : pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
`endif
         default: return pk(1,0,0,0,0,0,0,0,0,0,0,0,0,0);
      endcase
   endfunction

   task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, o, e);
      end
   endtask

   task automatic invariants();
      check("bus_onehot", 32'(($countones(Rout) + 32'(Gout) + 32'(DINout)) <= 1), 32'd1);
      check("pc_conflict", 32'(Rin[7] & (PCinc | PCclr)), 32'd0);
      check("w_with_doutin", 32'(W & ~DOUTin), 32'd0);
   endtask

   task automatic cyc(input logic run, input logic [9:0] ir, input logic g,
                      input logic [28:0] e, input string tag);
      @(posedge Clock);
      #1;
      Run = run;
      IR  = ir;
      Gnz = g;
      @(negedge Clock);
      check(tag, 32'(obs), 32'(e));
      invariants();
   endtask

   task automatic idle(input logic run);
      cyc(run, 10'($urandom), 1'($urandom), 29'd0, "idle");
      next_f0 = run;
   endtask

   task automatic instr(input logic [3:0] op, input logic [2:0] x, input logic [2:0] y,
                        input logic g, input logic run_next, input string tag);
      int n;
      if (!next_f0) idle(1'b1);
      n = instr_len(op);
      for (int k = 0; k < n; k++)
         cyc((k == n - 1) ? run_next : 1'($urandom), {op, x, y}, g, exp_step(op, x, y, g, k), tag);
      next_f0 = run_next;
   endtask

   initial begin
      #3;
      check("reset_async", 32'(obs), 32'(pk(0,0,0,0,0,1,0,0,0,0,0,0,0,0)));
      repeat (2) @(posedge Clock);
      #1 Reset = 1'b0;
      @(negedge Clock);
      check("rstpc_cycle", 32'(obs), 32'(pk(0,0,0,0,0,1,0,0,0,0,0,0,0,0)));
      idle(1'b0);
      idle(1'b0);

      instr(4'b0000, 3'd3, 3'd5, 1'b0, 1'b0, "mv_r3_r5");
      idle(1'b0);
      instr(4'b0010, 3'd1, 3'd2, 1'b0, 1'b1, "add_r1_r2");
      instr(4'b0011, 3'd1, 3'd2, 1'b0, 1'b0, "sub_r1_r2");
      instr(4'b0101, 3'd4, 3'd6, 1'b1, 1'b0, "st_r4_r6");
      instr(4'b0110, 3'd0, 3'd1, 1'b0, 1'b1, "mvnz_gnz0");
      instr(4'b0110, 3'd0, 3'd1, 1'b1, 1'b0, "mvnz_gnz1");
      instr(4'b0001, 3'd7, 3'd0, 1'b0, 1'b1, "mvi_r7");
      instr(4'b0000, 3'd7, 3'd2, 1'b0, 1'b0, "mv_jump");
      instr(4'b1111, 3'd7, 3'd7, 1'b1, 1'b0, "nop");

      // Reset asserted in the middle of F1.
      idle(1'b1);
      cyc(1'b1, 10'b0010_001_010, 1'b0, exp_step(4'd2, 3'd1, 3'd2, 1'b0, 0), "rst_f0");
      cyc(1'b1, 10'b0010_001_010, 1'b0, exp_step(4'd2, 3'd1, 3'd2, 1'b0, 1), "rst_f1");
      #2 Reset = 1'b1;
      #1 check("reset_mid_f1", 32'(obs), 32'(pk(0,0,0,0,0,1,0,0,0,0,0,0,0,0)));
      @(posedge Clock);
      #1 Reset = 1'b0;
      Run = 1'b0;
      @(negedge Clock);
      check("rstpc_after_release", 32'(obs), 32'(pk(0,0,0,0,0,1,0,0,0,0,0,0,0,0)));
      next_f0 = 1'b0;
      idle(1'b0);

      for (int i = 0; i < 250; i++) begin
         if (!next_f0 && ($urandom_range(0, 3) == 0)) idle(1'b0);
         instr(4'($urandom), 3'($urandom), 3'($urandom), 1'($urandom), 1'($urandom), "random");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL timeout checks=%0d", checks);
      $fatal(1, "bench time limit expired");
   end

endmodule
